alu_req_arbiter: RTL

Two-channel controller that shares one `ALU_8Bit` instance between two requesters (e.g. the CPU core and a DMA/peripheral engine). It accepts one operation at a time through a valid/ready handshake, uses round-robin arbitration, registers operands, drives the ALU, and waits extra cycles for multiply/divide. It then captures the result and flags and returns them to the winning requester as a one-cycle response pulse. It sits between the requesters and the ALU; the ALU itself remains combinational.

---
 rtl/alu_req_arbiter.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/alu_req_arbiter.sv
// alu_req_arbiter: round-robin front end that shares one combinational
// ALU between two requesters, with registered operands and mul/div wait.
module alu_req_arbiter #(
  parameter int unsigned MULDIV_WAIT = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [7:0] req0_a,
  input  logic [7:0] req0_b,
  input  logic [2:0] req0_op,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [7:0] req1_a,
  input  logic [7:0] req1_b,
  input  logic [2:0] req1_op,
  output logic       rsp0_valid,
  output logic       rsp1_valid,
  output logic [7:0] rsp_data,
  output logic [3:0] rsp_flags,
  output logic       rsp_err,
  output logic       busy,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [2:0] alu_op_select,
  output logic       alu_sub,
  input  logic [7:0] alu_result,
  input  logic       alu_cout,
  input  logic       alu_overflow,
  input  logic       alu_no,
  input  logic       alu_zo
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    WAIT,
    DONE
  } state_t;

  localparam logic [3:0] WAIT_LD =
    (MULDIV_WAIT > 0) ? 4'(MULDIV_WAIT - 1) : 4'd0;

  state_t     state;
  logic       ptr;
  logic       owner;
  logic [3:0] cnt;
  logic       idle;
  logic       gnt0;
  logic       gnt1;
  logic       is_muldiv;
  logic       is_ill;
  logic       wait_en;
  logic       do_cap;
  logic [7:0] cap_data;
  logic [3:0] cap_flags;
  logic       cap_err;

  // ready is gated by rst_n so it drops the instant reset asserts
  assign idle = rst_n && (state == IDLE);
  assign gnt0 = req0_valid && (!req1_valid || !ptr);
  assign gnt1 = req1_valid && (!req0_valid || ptr);
  assign req0_ready = idle && gnt0;
  assign req1_ready = idle && gnt1;

  assign busy = (state != IDLE);
  assign alu_sub = (alu_op_select == 3'd1);

  assign is_muldiv = (alu_op_select == 3'd4)
                  || (alu_op_select == 3'd5);
  assign is_ill = alu_op_select[2] && alu_op_select[1];
  assign wait_en = is_muldiv && (MULDIV_WAIT > 0);

  assign do_cap = ((state == EXEC) && !wait_en)
               || ((state == WAIT) && (cnt == 4'd0));

  always_comb begin
    cap_data  = alu_result;
    cap_flags = {3'b000, alu_result == 8'h00};
    cap_err   = 1'b0;
    unique case (1'b1)
      is_ill,
      (alu_op_select == 3'd5 && alu_b == 8'h00): begin
        cap_data  = 8'h00;
        cap_flags = 4'b0001;
        cap_err   = 1'b1;
      end
      (alu_op_select[2:1] == 2'b00): begin
        cap_flags = {alu_cout, alu_overflow, alu_no, alu_zo};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      ptr           <= 1'b0;
      owner         <= 1'b0;
      cnt           <= 4'd0;
      rsp0_valid    <= 1'b0;
      rsp1_valid    <= 1'b0;
      rsp_data      <= 8'h00;
      rsp_flags     <= 4'h0;
      rsp_err       <= 1'b0;
      alu_a         <= 8'h00;
      alu_b         <= 8'h00;
      alu_op_select <= 3'd0;
    end else begin
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      if (do_cap) begin
        rsp_data   <= cap_data;
        rsp_flags  <= cap_flags;
        rsp_err    <= cap_err;
        rsp0_valid <= !owner;
        rsp1_valid <= owner;
      end
      unique case (state)
        IDLE: begin
          if (req0_ready || req1_ready) begin
            owner         <= req1_ready;
            alu_a         <= req1_ready ? req1_a : req0_a;
            alu_b         <= req1_ready ? req1_b : req0_b;
            alu_op_select <= req1_ready ? req1_op : req0_op;
            state         <= EXEC;
          end
        end
        EXEC: begin
          if (wait_en) begin
            cnt   <= WAIT_LD;
            state <= WAIT;
          end else begin
            state <= DONE;
          end
        end
        WAIT: begin
          if (cnt == 4'd0) begin
            state <= DONE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE: begin
          ptr   <= !owner;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
